bit_serializer: RTL and testbench
=================================

BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 Parameter WIDTH, default 8: maximum word length in bits.
REQ-002 Parameter GAP, default 0: idle cycles inserted after each word before the next word starts shifting.
REQ-003 clk  in  1  single clock; all state changes on posedge clk.
REQ-004 rst  in  1  synchronous, active-high reset, sampled on posedge clk.
REQ-005 load_valid  in  1  upstream offers a word.
REQ-006 load_ready  out  1  block can accept a word this cycle.
REQ-007 data_in  in  WIDTH  word to serialize.
REQ-008 len  in  $clog2(WIDTH+1)  bit count 1..WIDTH; 0 or values above WIDTH mean WIDTH.
REQ-009 msb_first  in  1  1 = send the bit at index len-1 first, then down to bit 0; 0 = send bit 0 first, then up to bit len-1.
REQ-010 x  out  1  serial bit driven into the downstream sequence-detector input.
REQ-011 x_valid  out  1  x carries a payload bit this cycle.
REQ-012 done  out  1  one-cycle pulse, high in the cycle the last bit of a word is presented.
REQ-013 busy  out  1  high in SHIFT or GAP.

Function
REQ-014 The FSM SHALL have states IDLE, SHIFT and GAP.
REQ-015 A transfer SHALL occur on a posedge where load_valid=1, load_ready=1 and rst=0; data_in, the resolved len and msb_first SHALL be captured at that posedge.
REQ-016 load_ready SHALL be 1 in IDLE.
REQ-017 If GAP=0, load_ready SHALL also be 1 in the SHIFT cycle that presents the last bit; it SHALL be 0 in every other SHIFT cycle and in every GAP cycle.
REQ-018 load_ready SHALL be 0 while rst=1.
REQ-019 After a transfer, the first bit SHALL be on x with x_valid=1 in the next cycle; one bit per cycle SHALL follow with no bubbles.
REQ-020 A word of n bits SHALL occupy exactly n consecutive x_valid cycles.
REQ-021 done SHALL be 1 together with the nth bit.
REQ-022 After the last bit: if GAP>0, go to GAP for exactly GAP cycles, then to IDLE.
REQ-023 After the last bit: if GAP=0 and a transfer occurs in that cycle, stay in SHIFT with the new word's first bit next cycle (back-to-back); otherwise go to IDLE.
REQ-024 In IDLE and GAP: x=0, x_valid=0, done=0.
REQ-025 Inputs SHALL be ignored while load_ready=0; a held load_valid SHALL be accepted on the first cycle load_ready rises.
REQ-026 The internal bit counter SHALL be $clog2(WIDTH+1) bits wide and SHALL NOT wrap: it is loaded with n and decremented to 1 at the last bit.

Reset
REQ-027 When rst=1 at a posedge: state=IDLE; x=0, x_valid=0, done=0, busy=0; shift register and counter cleared.
REQ-028 rst SHALL take priority over any transfer or shift in the same cycle.
REQ-029 Reset mid-word SHALL abort the word with no further x_valid cycles and no done pulse.
REQ-030 After rst falls, load_ready=1 in the first cycle.

Structure
REQ-031 Shared package bit_serializer_pkg SHALL hold the state enum (IDLE, SHIFT, GAP) and the default WIDTH/GAP constants.
REQ-032 One sub-module ser_shreg: WIDTH-bit loadable shift register with direction select and serial output.
REQ-033 The FSM and the counter SHALL live in bit_serializer.

Verification
REQ-034 data_in=8'b1011_0010, len=8, msb_first=1, GAP=0 -> x=1,0,1,1,0,0,1,0 on 8 consecutive x_valid cycles; done on the 8th.
REQ-035 data_in=8'b0000_0110, len=3, msb_first=0 -> x=0,1,1; done on the 3rd; load_ready=1 the cycle after.
REQ-036 len=0, data_in=8'hFF -> 8 x_valid cycles, all ones.
REQ-037 GAP=0 with load_valid held for two words (8'hA5 then 8'h3C, msb_first) -> 16 contiguous x_valid cycles 10100101 00111100; done on the 8th and 16th.
REQ-038 GAP=2 -> exactly 2 x_valid=0 cycles between words; load_valid during SHIFT/GAP is not accepted.
REQ-039 rst=1 at the 4th bit of 8'hF0 -> next cycle x_valid=0, busy=0, no done pulse, load_ready=1 one cycle after rst falls.

Source files
------------

// File: rtl/bit_serializer_pkg.sv
// bit_serializer_pkg: shared FSM states and default sizes for the bit serializer
package bit_serializer_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;
    localparam int DEF_WIDTH = 8;
    localparam int DEF_GAP = 0;
endpackage

// File: rtl/ser_shreg.sv
// ser_shreg: loadable shift register emitting one bit per shift from the end chosen at load
module ser_shreg import bit_serializer_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic             msb_first,
    input  logic [WIDTH-1:0] data_in,
    output logic             ser
);
    logic [WIDTH-1:0] q;
    logic dir;
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
            dir <= 1'b0;
        end else if (load) begin
            q <= data_in;
            dir <= msb_first;
        end else if (shift) begin
            q <= dir ? q << 1 : q >> 1;
        end
    end
    assign ser = dir ? q[WIDTH-1] : q[0];
endmodule

// File: rtl/bit_serializer.sv
// bit_serializer: turns handshaked words of 1..WIDTH bits into a gapless serial bit stream
module bit_serializer import bit_serializer_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH,
    parameter int GAP = DEF_GAP
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load_valid,
    output logic                       load_ready,
    input  logic [WIDTH-1:0]           data_in,
    input  logic [$clog2(WIDTH+1)-1:0] len,
    input  logic                       msb_first,
    output logic                       x,
    output logic                       x_valid,
    output logic                       done,
    output logic                       busy
);
    localparam int LW = $clog2(WIDTH+1);
    localparam int GW = GAP > 0 ? $clog2(GAP+1) : 1;
    state_t state;
    logic [LW-1:0] cnt, n;
    logic [GW-1:0] gcnt;
    logic [WIDTH-1:0] aligned;
    logic xfer, last, ser;
    always_comb begin
        n = (len == '0 || int'(len) > WIDTH) ? LW'(WIDTH) : len;
        // msb-first words are left-aligned so bit n-1 sits at the top of the register
        aligned = msb_first ? data_in << (WIDTH - int'(n)) : data_in;
        last = state == SHIFT && cnt == LW'(1);
        load_ready = !rst && (state == IDLE || (GAP == 0 && last));
        xfer = load_valid && load_ready;
        x = x_valid & ser;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            gcnt <= '0;
            x_valid <= 1'b0;
            done <= 1'b0;
            busy <= 1'b0;
        end else if (xfer) begin
            state <= SHIFT;
            cnt <= n;
            x_valid <= 1'b1;
            done <= n == LW'(1);
            busy <= 1'b1;
        end else if (last) begin
            state <= GAP > 0 ? bit_serializer_pkg::GAP : IDLE;
            cnt <= '0;
            gcnt <= GW'(GAP);
            x_valid <= 1'b0;
            done <= 1'b0;
            busy <= GAP > 0;
        end else if (state == SHIFT) begin
            cnt <= cnt - 1'b1;
            done <= cnt == LW'(2);
        end else if (state == bit_serializer_pkg::GAP) begin
            if (gcnt == GW'(1)) begin
                state <= IDLE;
                busy <= 1'b0;
            end
            gcnt <= gcnt - 1'b1;
        end
    end
    ser_shreg #(.WIDTH(WIDTH)) u_shreg (
        .clk(clk),
        .rst(rst),
        .load(xfer),
        .shift(state == SHIFT),
        .msb_first(msb_first),
        .data_in(aligned),
        .ser(ser)
    );
endmodule

// File: tb/tb_bit_serializer.sv
// tb_bit_serializer: two instances (GAP=0, GAP=2) checked every cycle against a bit-queue model
module tb_bit_serializer;
    logic clk = 0;
    logic rst;
    logic lv[2];
    logic [7:0] dat[2];
    logic [3:0] ln[2];
    logic mf[2];
    logic rdy[2], xo[2], xv[2], dn[2], bz[2];
    int checks = 0, errors = 0, cyc = 0;
    bit chk = 0;
    int G[2] = '{0, 2};
    bit mq[2][$];
    int gl[2];
    int nn;
    bit tk;
    logic [63:0] acc[2];
    int cnt[2], dcnt[2], run[2], maxrun[2], gapc[2];
    int rise[2][$];
    bit pxv[2];

    always #5 clk = ~clk;

    bit_serializer #(.WIDTH(8), .GAP(0)) dut0 (
        .clk(clk), .rst(rst), .load_valid(lv[0]), .load_ready(rdy[0]), .data_in(dat[0]),
        .len(ln[0]), .msb_first(mf[0]), .x(xo[0]), .x_valid(xv[0]), .done(dn[0]), .busy(bz[0])
    );
    bit_serializer #(.WIDTH(8), .GAP(2)) dut2 (
        .clk(clk), .rst(rst), .load_valid(lv[1]), .load_ready(rdy[1]), .data_in(dat[1]),
        .len(ln[1]), .msb_first(mf[1]), .x(xo[1]), .x_valid(xv[1]), .done(dn[1]), .busy(bz[1])
    );

    // Model: queue of bits still to be presented (head = current bit) plus remaining gap cycles
    function automatic bit m_ready(int d);
        return !rst && ((mq[d].size() == 0 && gl[d] == 0) || (G[d] == 0 && mq[d].size() == 1));
    endfunction

    always @(posedge clk) begin
        cyc++;
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                mq[d].delete();
                gl[d] = 0;
            end else begin
                tk = lv[d] && m_ready(d);
                if (gl[d] > 0) gl[d]--;
                else if (mq[d].size() > 0) begin
                    void'(mq[d].pop_front());
                    if (mq[d].size() == 0) gl[d] = G[d];
                end
                if (tk) begin
                    nn = (ln[d] == 0 || ln[d] > 8) ? 8 : int'(ln[d]);
                    for (int i = 0; i < nn; i++) mq[d].push_back(mf[d] ? dat[d][nn-1-i] : dat[d][i]);
                end
            end
        end
    end

    task automatic cmp(string nm, int d, logic a, logic e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s dut%0d cyc=%0d got=%b want=%b", nm, d, cyc, a, e);
        end
    endtask

    task automatic lit(string nm, logic [63:0] a, logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", nm, a, e);
        end
    endtask

    always @(negedge clk) begin
        if (chk) begin
            for (int d = 0; d < 2; d++) begin
                cmp("x_valid", d, xv[d], mq[d].size() > 0);
                cmp("x", d, xo[d], mq[d].size() > 0 ? mq[d][0] : 1'b0);
                cmp("done", d, dn[d], mq[d].size() == 1);
                cmp("busy", d, bz[d], mq[d].size() > 0 || gl[d] > 0);
                cmp("load_ready", d, rdy[d], m_ready(d));
                if (xv[d] === 1'b1) begin
                    acc[d] = {acc[d][62:0], xo[d]};
                    cnt[d]++;
                    run[d]++;
                    if (run[d] > maxrun[d]) maxrun[d] = run[d];
                    if (!pxv[d]) rise[d].push_back(cyc);
                end else run[d] = 0;
                if (dn[d] === 1'b1) dcnt[d]++;
                if (bz[d] === 1'b1 && xv[d] !== 1'b1) gapc[d]++;
                pxv[d] = xv[d] === 1'b1;
            end
        end
    end

    task automatic clr();
        for (int d = 0; d < 2; d++) begin
            acc[d] = 0; cnt[d] = 0; dcnt[d] = 0; run[d] = 0; maxrun[d] = 0; gapc[d] = 0;
            rise[d].delete();
        end
    endtask

    task automatic send(int d, logic [7:0] w, logic [3:0] n, logic m);
        bit ok = 0;
        lv[d] = 1; dat[d] = w; ln[d] = n; mf[d] = m;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            ok = rdy[d] === 1'b1;
            @(posedge clk);
            #1;
        end
        lit("handshake", ok, 1);
        lv[d] = 0;
    endtask

    task automatic wait_idle(int d);
        bit ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = bz[d] === 1'b0 && xv[d] === 1'b0;
        end
        lit("idle_wait", ok, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1;
        for (int d = 0; d < 2; d++) begin
            lv[d] = 0; dat[d] = 0; ln[d] = 0; mf[d] = 0; gl[d] = 0; pxv[d] = 0;
        end
        clr();
        @(posedge clk);
        @(negedge clk);
        lit("rst_ready", rdy[0], 0);
        lit("rst_xvalid", xv[0], 0);
        lit("rst_busy", bz[0], 0);
        lit("rst_done", dn[1], 0);
        @(posedge clk);
        #1 rst = 0;
        chk = 1;
        @(negedge clk);
        lit("ready_after_rst", rdy[0], 1);
        @(posedge clk);
        #1;
        clr();
        send(0, 8'b1011_0010, 8, 1);
        wait_idle(0);
        lit("w_b2_bits", acc[0][7:0], 8'b1011_0010);
        lit("w_b2_count", cnt[0], 8);
        lit("w_b2_done", dcnt[0], 1);
        clr();
        send(0, 8'b0000_0110, 3, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        lit("w_06_ready_after", rdy[0], 1);
        lit("w_06_bits", acc[0][2:0], 3'b011);
        lit("w_06_count", cnt[0], 3);
        lit("w_06_done", dcnt[0], 1);
        wait_idle(0);
        clr();
        send(0, 8'hFF, 0, 1);
        wait_idle(0);
        lit("len0_bits", acc[0][7:0], 8'hFF);
        lit("len0_count", cnt[0], 8);
        clr();
        send(0, 8'hA5, 8, 1);
        send(0, 8'h3C, 8, 1);
        wait_idle(0);
        lit("b2b_bits", acc[0][15:0], 16'hA53C);
        lit("b2b_count", cnt[0], 16);
        lit("b2b_done", dcnt[0], 2);
        lit("b2b_contig", maxrun[0], 16);
        clr();
        send(1, 8'hC3, 8, 1);
        send(1, 8'h5A, 8, 0);
        wait_idle(1);
        lit("gap_count", cnt[1], 16);
        lit("gap_cycles", gapc[1], 4);
        lit("gap_words", rise[1].size(), 2);
        if (rise[1].size() == 2) lit("gap_spacing", rise[1][1] - rise[1][0], 11);
        clr();
        send(0, 8'hF0, 8, 1);
        repeat (3) @(posedge clk);
        #1 rst = 1;
        @(posedge clk);
        @(negedge clk);
        lit("abort_xvalid", xv[0], 0);
        lit("abort_busy", bz[0], 0);
        lit("abort_ready_in_rst", rdy[0], 0);
        lit("abort_bits", cnt[0], 4);
        lit("abort_prefix", acc[0][3:0], 4'hF);
        lit("abort_done", dcnt[0], 0);
        @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        lit("abort_ready_after", rdy[0], 1);
        for (int c = 0; c < 2000; c++) begin
            @(posedge clk);
            #1;
            for (int d = 0; d < 2; d++) begin
                lv[d] = ($urandom % 3) != 0;
                dat[d] = 8'($urandom);
                ln[d] = 4'($urandom % 16);
                mf[d] = 1'($urandom);
            end
            rst = ($urandom % 100) == 0;
        end
        @(posedge clk);
        #1;
        rst = 0; lv[0] = 0; lv[1] = 0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
